// File: rtl/alu_share_ctrl.sv
// Arbitrates two requesters onto one shared combinational ALU, one transaction
// in flight, with round-robin priority and a registered result per transaction.
module alu_share_ctrl #(
   parameter int N          = 32,
   parameter int MULDIV_LAT = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   input  logic [4:0]   req0_ctrl,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [4:0]   req1_ctrl,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   output logic         req1_ready,
   output logic         resp0_valid,
   input  logic         resp0_ready,
   output logic         resp1_valid,
   input  logic         resp1_ready,
   output logic [N-1:0] resp_result,
   output logic         resp_err,
   output logic [4:0]   alu_ctrl,
   output logic [N-1:0] src_A,
   output logic [N-1:0] src_B,
   input  logic [N-1:0] alu_result,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [3:0] LAT_M1 = 4'(MULDIV_LAT - 1);

   state_t       state, state_nxt;
   logic         prio;
   logic         grant_idx;
   logic [4:0]   cap_ctrl;
   logic [N-1:0] cap_a, cap_b;
   logic [3:0]   cnt;

   logic         grant_sel;
   logic         accept;
   logic         consume;
   logic [4:0]   sel_ctrl;
   logic [N-1:0] sel_a, sel_b;

   function automatic logic is_defined(input logic [4:0] c);
      case (c)
         5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd9, 5'd10, 5'd11, 5'd12,
         5'd17, 5'd19, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // A lone valid wins outright; on contention prio picks the requester.
   assign grant_sel = req0_valid ? (req1_valid ? prio : 1'b0) : 1'b1;
   assign sel_ctrl  = grant_sel ? req1_ctrl : req0_ctrl;
   assign sel_a     = grant_sel ? req1_a    : req0_a;
   assign sel_b     = grant_sel ? req1_b    : req0_b;
   assign busy      = (state != IDLE);

   always_comb begin
      state_nxt   = state;
      accept      = 1'b0;
      consume     = 1'b0;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      resp0_valid = 1'b0;
      resp1_valid = 1'b0;
      alu_ctrl    = '0;
      src_A       = '0;
      src_B       = '0;
      case (state)
         IDLE: begin
            if (req0_valid || req1_valid) begin
               accept     = 1'b1;
               req0_ready = ~grant_sel;
               req1_ready = grant_sel;
               state_nxt  = EXEC;
            end
         end
         EXEC: begin
            alu_ctrl = cap_ctrl;
            src_A    = cap_a;
            src_B    = cap_b;
            if (cnt == 4'd0) state_nxt = RESP;
         end
         RESP: begin
            resp0_valid = ~grant_idx;
            resp1_valid = grant_idx;
            consume     = grant_idx ? resp1_ready : resp0_ready;
            if (consume) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Undefined opcodes still spend one EXEC cycle but report zero with err set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         prio        <= 1'b0;
         grant_idx   <= 1'b0;
         cap_ctrl    <= '0;
         cap_a       <= '0;
         cap_b       <= '0;
         cnt         <= '0;
         resp_result <= '0;
         resp_err    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            grant_idx <= grant_sel;
            cap_ctrl  <= sel_ctrl;
            cap_a     <= sel_a;
            cap_b     <= sel_b;
            cnt       <= (sel_ctrl == 5'd3 || sel_ctrl == 5'd5) ? LAT_M1 : 4'd0;
         end
         if (state == EXEC) begin
            if (cnt == 4'd0) begin
               resp_result <= is_defined(cap_ctrl) ? alu_result : '0;
               resp_err    <= ~is_defined(cap_ctrl);
            end else begin
               cnt <= cnt - 4'd1;
            end
         end
         if (state == RESP && consume) prio <= ~grant_idx;
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: a stub ALU, a vector table driven through a
// response scoreboard, and directed contention/backpressure/reset sequences.
module tb_alu_share_ctrl;

   localparam int N   = 32;
   localparam int LAT = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0_valid, req1_valid;
   logic [4:0]   req0_ctrl, req1_ctrl;
   logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         req0_ready, req1_ready;
   logic         resp0_valid, resp1_valid;
   logic         resp0_ready, resp1_ready;
   logic [N-1:0] resp_result;
   logic         resp_err;
   logic [4:0]   alu_ctrl;
   logic [N-1:0] src_A, src_B, alu_result;
   logic         busy;

   int n_checks = 0;
   int n_fail   = 0;

   alu_share_ctrl #(.N(N), .MULDIV_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ctrl(req0_ctrl), .req0_a(req0_a), .req0_b(req0_b),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_ctrl(req1_ctrl), .req1_a(req1_a), .req1_b(req1_b),
      .req1_ready(req1_ready),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .resp_result(resp_result), .resp_err(resp_err),
      .alu_ctrl(alu_ctrl), .src_A(src_A), .src_B(src_B),
      .alu_result(alu_result), .busy(busy)
   );

   always #5 clk = ~clk;

   // Stub of the shared ALU; undefined codes return garbage the DUT must mask.
   function automatic logic [N-1:0] alu_model(input logic [4:0] c, input logic [N-1:0] a, input logic [N-1:0] b);
      case (c)
         5'd1:  return a + b;
         5'd2:  return a - b;
         5'd3:  return a * b;
         5'd4:  return a & b;
         5'd5:  return (b != 0) ? a / b : '1;
         5'd6:  return a | b;
         5'd9:  return a ^ b;
         5'd10: return a << b[4:0];
         5'd11: return a >> b[4:0];
         5'd12: return $signed(a) >>> b[4:0];
         5'd17: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         5'd19: return (a < b) ? 32'd1 : 32'd0;
         5'd25: return ~a;
         5'd26: return ~(a & b);
         5'd27: return ~(a | b);
         5'd28: return a + 32'd1;
         5'd29: return a - 32'd1;
         5'd30: return b;
         default: return 32'hDEADBEEF;
      endcase
   endfunction

   always_comb alu_result = alu_model(alu_ctrl, src_A, src_B);

   typedef struct {
      bit           port;
      logic [4:0]   ctrl;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] exp_res;
      logic         exp_err;
   } vec_t;

   typedef struct {
      bit           port;
      logic [N-1:0] res;
      logic         err;
   } sb_t;

   sb_t sb_q[$];

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_stimulus(input bit port, input logic [4:0] c, input logic [N-1:0] a, input logic [N-1:0] b);
      if (port) begin
         req1_valid = 1'b1; req1_ctrl = c; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_ctrl = c; req0_a = a; req0_b = b;
      end
   endtask

   // Called at a negedge in IDLE; returns at a negedge back in IDLE.
   task automatic run_txn(input vec_t v);
      int  n;
      int  exp_lat;
      sb_t s;
      exp_lat = (v.ctrl == 5'd3 || v.ctrl == 5'd5) ? 1 + LAT : 2;
      apply_stimulus(v.port, v.ctrl, v.a, v.b);
      #1;
      check_output("req_ready_granted", v.port ? req1_ready : req0_ready, 1'b1);
      sb_q.push_back('{v.port, v.exp_res, v.exp_err});
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      n = 1;
      while (!(v.port ? resp1_valid : resp0_valid) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_output("resp_latency", n, exp_lat);
      if (sb_q.size() == 0) begin
         check_output("scoreboard_empty", 1'b1, 1'b0);
      end else begin
         s = sb_q.pop_front();
         check_output("resp_port", v.port, s.port);
         check_output("resp_result", resp_result, s.res);
         check_output("resp_err", resp_err, s.err);
      end
      check_output("other_resp_valid", v.port ? resp0_valid : resp1_valid, 1'b0);
      if (v.port) resp1_ready = 1'b1; else resp0_ready = 1'b1;
      @(negedge clk);
      resp0_ready = 1'b0;
      resp1_ready = 1'b0;
      check_output("resp_valid_dropped", {resp0_valid, resp1_valid}, 2'b00);
      check_output("busy_after_consume", busy, 1'b0);
   endtask

   vec_t vecs[12];

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation timed out");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [N-1:0] held;
      bit           saw_resp;
      int           n;

      vecs[0]  = '{1'b0, 5'd1,  32'd5,          32'd7,   32'd12,  1'b0};
      vecs[1]  = '{1'b1, 5'd5,  32'd20,         32'd4,   32'd5,   1'b0};
      vecs[2]  = '{1'b0, 5'd7,  32'd9,          32'd9,   32'd0,   1'b1};
      vecs[3]  = '{1'b1, 5'd3,  32'd6,          32'd7,   32'd42,  1'b0};
      vecs[4]  = '{1'b0, 5'd4,  32'hF0,         32'h3C,  32'h30,  1'b0};
      vecs[5]  = '{1'b1, 5'd9,  32'hFF,         32'h0F,  32'hF0,  1'b0};
      vecs[6]  = '{1'b0, 5'd10, 32'd1,          32'd4,   32'd16,  1'b0};
      vecs[7]  = '{1'b1, 5'd31, 32'd3,          32'd3,   32'd0,   1'b1};
      vecs[8]  = '{1'b0, 5'd0,  32'd1,          32'd2,   32'd0,   1'b1};
      vecs[9]  = '{1'b1, 5'd17, 32'hFFFFFFFF,   32'd1,   32'd1,   1'b0};
      vecs[10] = '{1'b0, 5'd30, 32'd1,          32'd99,  32'd99,  1'b0};
      vecs[11] = '{1'b1, 5'd2,  32'd10,         32'd3,   32'd7,   1'b0};

      rst_n = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_ctrl = '0; req1_ctrl = '0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      resp0_ready = 1'b0; resp1_ready = 1'b0;

      repeat (3) @(negedge clk);
      check_output("reset_busy", busy, 1'b0);
      check_output("reset_resp_valid", {resp0_valid, resp1_valid}, 2'b00);
      check_output("reset_result", {resp_err, resp_result}, 33'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_output("idle_ready", {req0_ready, req1_ready}, 2'b00);
      check_output("idle_alu", {alu_ctrl, src_A, src_B}, 69'd0);

      for (int i = 0; i < 12; i++) run_txn(vecs[i]);

      // Contention: prio restarts at 0 and alternates 0,1,0.
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      apply_stimulus(1'b0, 5'd2, 32'd10, 32'd3);
      apply_stimulus(1'b1, 5'd2, 32'd10, 32'd3);
      for (int k = 0; k < 3; k++) begin
         #1;
         check_output("contend_ready", {req1_ready, req0_ready}, (k % 2) ? 2'b10 : 2'b01);
         @(posedge clk);
         @(negedge clk);
         check_output("contend_no_ready_busy", {req1_ready, req0_ready}, 2'b00);
         n = 1;
         while (!((k % 2) ? resp1_valid : resp0_valid) && n < 40) begin
            @(negedge clk);
            n++;
         end
         check_output("contend_latency", n, 2);
         check_output("contend_result", resp_result, 32'd7);
         if (k % 2) resp1_ready = 1'b1; else resp0_ready = 1'b1;
         @(negedge clk);
         resp0_ready = 1'b0;
         resp1_ready = 1'b0;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);

      // Backpressure: response held while the other requester waits.
      apply_stimulus(1'b0, 5'd1, 32'd100, 32'd23);
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0;
      apply_stimulus(1'b1, 5'd1, 32'd1, 32'd1);
      @(negedge clk);
      check_output("bp_valid_start", resp0_valid, 1'b1);
      held = resp_result;
      check_output("bp_result", held, 32'd123);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check_output("bp_hold", {resp0_valid, req1_ready, resp1_valid, resp_result}, {3'b100, held});
      end
      req1_valid = 1'b0;
      resp0_ready = 1'b1;
      @(negedge clk);
      resp0_ready = 1'b0;
      check_output("bp_released", {busy, resp0_valid}, 2'b00);

      // Reset during a multi-cycle EXEC.
      apply_stimulus(1'b1, 5'd5, 32'd20, 32'd4);
      @(posedge clk);
      @(negedge clk);
      req1_valid = 1'b0;
      @(negedge clk);
      check_output("midexec_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check_output("async_reset_busy", busy, 1'b0);
      check_output("async_reset_alu", {alu_ctrl, src_A, src_B}, 69'd0);
      check_output("async_reset_resp", {resp0_valid, resp1_valid, resp_err, resp_result}, 35'd0);
      @(negedge clk);
      rst_n = 1'b1;
      saw_resp = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (resp0_valid || resp1_valid || busy) saw_resp = 1'b1;
      end
      check_output("no_resp_after_reset", saw_resp, 1'b0);

      // prio returns to 0 after reset (last grant before it was req0).
      apply_stimulus(1'b0, 5'd1, 32'd2, 32'd2);
      apply_stimulus(1'b1, 5'd1, 32'd3, 32'd3);
      #1;
      check_output("prio_after_reset", {req1_ready, req0_ready}, 2'b01);
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      check_output("prio_after_reset_result", {resp0_valid, resp_result}, {1'b1, 32'd4});
      resp0_ready = 1'b1;
      @(negedge clk);
      resp0_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_share_ctrl.md
ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

Interface
REQ-001 Parameter N, default 32: operand/result width.
REQ-002 Parameter MULDIV_LAT, default 3, legal 1..15: EXEC cycles for multiply (ctrl 3) and divide (ctrl 5).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid / req1_valid  input  1  requester k presents an operation.
REQ-006 req0_ctrl / req1_ctrl  input  5  ALU operation code of requester k.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  N  operands of requester k.
REQ-008 req0_ready / req1_ready  output  1  requester k's operation accepted this cycle.
REQ-009 resp0_valid / resp1_valid  output  1  result for requester k available.
REQ-010 resp0_ready / resp1_ready  input  1  requester k consumes its result.
REQ-011 resp_result  output  N  registered result, shared by both response ports.
REQ-012 resp_err  output  1  high with resp_kvalid when the opcode was not a defined ALU code.
REQ-013 alu_ctrl  output  5, src_A  output  N, src_B  output  N  drive the shared ALU.
REQ-014 alu_result  input  N  combinational result from the shared ALU.
REQ-015 busy  output  1  high in any state except IDLE.

Function
REQ-016 FSM states: IDLE, EXEC, RESP; one transaction in flight at a time.
REQ-017 IDLE, no valid: alu_ctrl=0, src_A=0, src_B=0, both ready=0, state held.
REQ-018 IDLE, a valid present: grant one requester; its req_ready=1 combinationally in that cycle; ctrl/a/b captured; next state EXEC.
REQ-019 Only one valid: that requester is granted regardless of priority.
REQ-020 Both valid: the requester selected by priority bit prio (0 -> req0, 1 -> req1) is granted; the other's ready stays 0.
REQ-021 prio updates to the inverse of the granted index on the RESP->IDLE transition only.
REQ-022 req_ready is never asserted outside IDLE.
REQ-023 EXEC: alu_ctrl/src_A/src_B driven from captured registers, stable for the whole state.
REQ-024 EXEC length: MULDIV_LAT cycles for ctrl 3 or 5, 1 cycle for all other codes; 4-bit down-counter.
REQ-025 Last EXEC cycle: alu_result captured into resp_result; next state RESP.
REQ-026 Defined codes: 1,2,3,4,5,6,9,10,11,12,17,19,25..30; any other code executes for 1 cycle, result 0, resp_err=1.
REQ-027 RESP: resp_kvalid=1 for granted requester only; resp_result and resp_err held stable.
REQ-028 RESP with matching resp_kready=1: next state IDLE; resp_kvalid falls next cycle.
REQ-029 RESP without resp_kready: held indefinitely; new requests not accepted.
REQ-030 Latency: accept at cycle T -> resp_valid at T+2 (single-cycle op) or T+1+MULDIV_LAT (mul/div).
REQ-031 Back-to-back: earliest next accept is the cycle after the RESP->IDLE transition.
REQ-032 Non-granted resp_ready and request inputs ignored outside IDLE.

Reset
REQ-033 rst_n low: immediately state=IDLE, prio=0, counter=0, resp_result=0, resp_err=0, all valid/ready=0, busy=0, ALU drives 0.
REQ-034 Reset mid-EXEC or mid-RESP: transaction discarded, no response issued after release.
REQ-035 First accept possible in first rising edge with rst_n high.

Verification
REQ-036 Req0 only, ctrl=1, a=5, b=7, resp0_ready=1 -> req0_ready at T, resp0_valid at T+2, resp_result=12, resp_err=0.
REQ-037 Both valid after reset, ctrl=2, a=10, b=3 each -> req0 granted first (7), then req1 granted, prio alternates on following contention.
REQ-038 Req1 ctrl=5, MULDIV_LAT=3, a=20, b=4 -> busy 3 EXEC cycles, resp1_valid at T+4, resp_result=5.
REQ-039 Req0 ctrl=7 -> resp_result=0, resp_err=1, 1-cycle EXEC.
REQ-040 resp0_ready held low 10 cycles while req1_valid=1 -> resp0_valid/resp_result stable, req1_ready=0 throughout.
REQ-041 rst_n pulsed low during EXEC -> all outputs 0 asynchronously, no resp_valid after release.
